// File: rtl/placement_readback_checker.sv
// Audits placement result memories: grid/position consistency, then edge
// legality, streaming per-edge Manhattan and 1-hop costs over valid/ready.
module placement_readback_checker #(
    parameter int N      = 4,
    parameter int N_EDGE = 19,
    parameter int W      = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [2:0]          err_code,
    output logic [W-1:0]        err_index,
    output logic [W-1:0]        sum,
    output logic [W-1:0]        sum_1hop,
    output logic [W-1:0]        cycles,
    output logic                ea_re,
    output logic                eb_re,
    output logic [W-1:0]        ea_addr,
    output logic [W-1:0]        eb_addr,
    input  logic signed [W-1:0] ea_dout,
    input  logic signed [W-1:0] eb_dout,
    output logic                px_re,
    output logic                py_re,
    output logic [W-1:0]        px_addr,
    output logic [W-1:0]        py_addr,
    input  logic signed [W-1:0] px_dout,
    input  logic signed [W-1:0] py_dout,
    output logic                grid_re,
    output logic [W-1:0]        grid_addr,
    input  logic signed [W-1:0] grid_dout,
    output logic                edge_valid,
    input  logic                edge_ready,
    output logic [W-1:0]        edge_idx,
    output logic [W-1:0]        edge_cost,
    output logic [W-1:0]        edge_hop
);
    typedef enum logic [3:0] {
        IDLE, GSCAN_RD, GSCAN_POS, GSCAN_CHK, EDGE_RD, EDGE_POSA,
        EDGE_POSB, EDGE_GRID, EDGE_CALC, EDGE_OUT, FIN
    } state_t;

    localparam logic signed [W-1:0] NS   = W'(N);
    localparam logic signed [W-1:0] NEG1 = '1;
    localparam logic signed [W-1:0] ONE  = W'(1);
    localparam logic signed [W-1:0] LAST_CELL = W'(N*N-1);
    localparam logic signed [W-1:0] LAST_EDGE = W'(N_EDGE-1);

    state_t state, state_n;
    logic signed [W-1:0] c, i, a, b, xa, ya, xb, yb;
    logic signed [W-1:0] dx, dy, cost_c, hop_c;
    logic [1:0] ph, ph_n;
    logic c_inc, ld_ab, ld_pa, ld_pb, ld_out, accept, err_set;
    logic unpl, oor, ovl;
    logic [2:0] err_n;
    logic [W-1:0] err_idx_n;

    assign busy = (state != IDLE) && (state != FIN);
    assign done = (state == FIN);

    // b's position is checked straight off the RAM output in the first grid phase
    assign unpl = xa == NEG1 || ya == NEG1 || px_dout == NEG1 || py_dout == NEG1;
    assign oor = xa < 0 || xa >= NS || ya < 0 || ya >= NS ||
                 px_dout < 0 || px_dout >= NS || py_dout < 0 || py_dout >= NS;
    assign ovl = a != b && xa == px_dout && ya == py_dout;

    assign dx = (xa > xb) ? xa - xb : xb - xa;
    assign dy = (ya > yb) ? ya - yb : yb - ya;
    assign cost_c = dx + dy - ONE;
    assign hop_c = (dx >>> 1) + {{(W-1){1'b0}}, dx[0]} +
                   (dy >>> 1) + {{(W-1){1'b0}}, dy[0]} - ONE;

    always_comb begin
        state_n   = state;
        ph_n      = ph;
        grid_re   = 1'b0;
        grid_addr = '0;
        px_re     = 1'b0;
        py_re     = 1'b0;
        px_addr   = '0;
        py_addr   = '0;
        ea_re     = 1'b0;
        eb_re     = 1'b0;
        ea_addr   = '0;
        eb_addr   = '0;
        c_inc     = 1'b0;
        ld_ab     = 1'b0;
        ld_pa     = 1'b0;
        ld_pb     = 1'b0;
        ld_out    = 1'b0;
        accept    = 1'b0;
        err_set   = 1'b0;
        err_n     = 3'd0;
        err_idx_n = '0;
        unique case (state)
            IDLE: if (start) state_n = GSCAN_RD;
            GSCAN_RD: begin
                grid_re   = 1'b1;
                grid_addr = c;
                state_n   = GSCAN_POS;
            end
            GSCAN_POS: begin
                if (grid_dout == NEG1) begin
                    c_inc = 1'b1;
                    if (c == LAST_CELL)
                        state_n = (N_EDGE == 0) ? FIN : EDGE_RD;
                    else
                        state_n = GSCAN_RD;
                end else begin
                    px_re   = 1'b1;
                    py_re   = 1'b1;
                    px_addr = grid_dout;
                    py_addr = grid_dout;
                    state_n = GSCAN_CHK;
                end
            end
            GSCAN_CHK: begin
                if (px_dout * NS + py_dout != c) begin
                    err_set   = 1'b1;
                    err_n     = 3'd1;
                    err_idx_n = c;
                end else begin
                    c_inc = 1'b1;
                    if (c == LAST_CELL)
                        state_n = (N_EDGE == 0) ? FIN : EDGE_RD;
                    else
                        state_n = GSCAN_RD;
                end
            end
            EDGE_RD: begin
                ea_re   = 1'b1;
                eb_re   = 1'b1;
                ea_addr = i;
                eb_addr = i;
                state_n = EDGE_POSA;
            end
            EDGE_POSA: begin
                ld_ab   = 1'b1;
                px_re   = 1'b1;
                py_re   = 1'b1;
                px_addr = ea_dout;
                py_addr = ea_dout;
                state_n = EDGE_POSB;
            end
            EDGE_POSB: begin
                ld_pa   = 1'b1;
                px_re   = 1'b1;
                py_re   = 1'b1;
                px_addr = b;
                py_addr = b;
                ph_n    = 2'd0;
                state_n = EDGE_GRID;
            end
            EDGE_GRID: begin
                if (ph == 2'd0) begin
                    ld_pb = 1'b1;
                    if (unpl || oor || ovl) begin
                        err_set   = 1'b1;
                        err_n     = unpl ? 3'd2 : (oor ? 3'd3 : 3'd5);
                        err_idx_n = i;
                    end else begin
                        grid_re   = 1'b1;
                        grid_addr = xa * NS + ya;
                        ph_n      = 2'd1;
                    end
                end else if (ph == 2'd1) begin
                    if (grid_dout != a) begin
                        err_set   = 1'b1;
                        err_n     = 3'd4;
                        err_idx_n = i;
                    end else begin
                        grid_re   = 1'b1;
                        grid_addr = xb * NS + yb;
                        ph_n      = 2'd2;
                    end
                end else begin
                    if (grid_dout != b) begin
                        err_set   = 1'b1;
                        err_n     = 3'd4;
                        err_idx_n = i;
                    end else begin
                        state_n = EDGE_CALC;
                    end
                end
            end
            EDGE_CALC: begin
                ld_out  = 1'b1;
                state_n = EDGE_OUT;
            end
            EDGE_OUT: begin
                if (edge_ready) begin
                    accept  = 1'b1;
                    state_n = (i == LAST_EDGE) ? FIN : EDGE_RD;
                end
            end
            FIN: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (err_set) state_n = FIN;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ph         <= 2'd0;
            c          <= '0;
            i          <= '0;
            a          <= '0;
            b          <= '0;
            xa         <= '0;
            ya         <= '0;
            xb         <= '0;
            yb         <= '0;
            pass       <= 1'b0;
            err_code   <= 3'd0;
            err_index  <= '0;
            sum        <= '0;
            sum_1hop   <= '0;
            cycles     <= '0;
            edge_valid <= 1'b0;
            edge_idx   <= '0;
            edge_cost  <= '0;
            edge_hop   <= '0;
        end else begin
            state <= state_n;
            ph    <= ph_n;
            if (busy) cycles <= cycles + W'(1);
            if (state == IDLE && start) begin
                sum       <= '0;
                sum_1hop  <= '0;
                cycles    <= '0;
                err_code  <= 3'd0;
                err_index <= '0;
                pass      <= 1'b0;
                c         <= '0;
                i         <= '0;
            end
            if (c_inc) c <= c + ONE;
            if (ld_ab) begin
                a <= ea_dout;
                b <= eb_dout;
            end
            if (ld_pa) begin
                xa <= px_dout;
                ya <= py_dout;
            end
            if (ld_pb) begin
                xb <= px_dout;
                yb <= py_dout;
            end
            if (ld_out) begin
                edge_valid <= 1'b1;
                edge_idx   <= i;
                edge_cost  <= cost_c;
                edge_hop   <= hop_c;
            end
            if (accept) begin
                edge_valid <= 1'b0;
                sum        <= sum + edge_cost;
                sum_1hop   <= sum_1hop + edge_hop;
                i          <= i + ONE;
            end
            if (err_set) begin
                err_code  <= err_n;
                err_index <= err_idx_n;
            end
            if (state_n == FIN && state != FIN) pass <= !err_set;
        end
    end
endmodule

// File: doc/placement_readback_checker.md
Name: placement_readback_checker

Overview:
- Post-placement reader/auditor for the placement engine's result memories: position X RAM, position Y RAM and the N×N grid RAM.
- After the engine finishes, it sweeps the grid and checks that every occupied cell agrees with the position RAMs.
- It then walks the edge list (ea/eb ROMs), checks that both endpoints are legally placed, and streams per-edge Manhattan and 1-hop costs over a valid/ready interface.
- It accumulates total costs and reports pass/fail with an error code.

Parameters:
- N, 4, grid side; cell index = x*N+y, cells 0..N*N-1.
- N_EDGE, 19, number of edges in the ea/eb ROMs.
- W, 32, data/address width; all memory data are signed W-bit; -1 = empty/unplaced.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; begins a check run when idle
- busy  out  1  high from the cycle after accepted start until the done cycle
- done  out  1  one-cycle pulse at end of run (pass or fail)
- pass  out  1  valid from done onward; 1 = no error
- err_code  out  3  0 none, 1 GRID_MISMATCH, 2 UNPLACED, 3 OUT_OF_RANGE, 4 POS_MISMATCH, 5 OVERLAP
- err_index  out  W  grid cell (code 1) or edge index (codes 2-5) of the first error
- sum  out  W  Σ(dx+dy-1) over all edges
- sum_1hop  out  W  Σ(ceil(dx/2)+ceil(dy/2)-1)
- cycles  out  W  cycles spent busy
- ea_re/eb_re  out  1  read strobes; ea_addr/eb_addr out W; ea_dout/eb_dout in W
- px_re/py_re  out  1  position RAM read strobes; px_addr/py_addr out W; px_dout/py_dout in W
- grid_re  out  1  grid read strobe; grid_addr out W; grid_dout in W
- edge_valid  out  1  per-edge record valid
- edge_ready  in  1  consumer accepts the record
- edge_idx  out  W  edge index of the current record
- edge_cost  out  W  dx+dy-1
- edge_hop  out  W  ceil(dx/2)+ceil(dy/2)-1

Behaviour:
- Reset values:
  - All strobes, busy, done, pass and edge_valid are 0.
  - err_code, err_index, sum, sum_1hop, cycles, edge_* and all addresses are 0.
  - The FSM returns to IDLE.
  - A reset mid-run aborts immediately: no done pulse, and memories are never written.
- Memory timing: dout is registered and valid in the cycle after the strobe cycle, held until the next strobe. The block samples dout only in that cycle.
- Strobes are 1-cycle pulses. The block never drives px_re and grid_re with conflicting addresses in the same cycle.
- FSM states: IDLE → GSCAN_RD → GSCAN_POS → GSCAN_CHK → EDGE_RD → EDGE_POSA → EDGE_POSB → EDGE_GRID → EDGE_CALC → EDGE_OUT → FIN.
- IDLE:
  - start clears sum, sum_1hop, cycles, err_code and err_index, then enters GSCAN_RD with cell c=0.
  - start while busy is ignored.
- GSCAN (grid scan):
  - Read grid[c].
  - If the cell is -1, advance c.
  - Otherwise, with v = cell value, read px[v] and py[v]. Fail with GRID_MISMATCH at c if px*N+py != c.
  - After c = N*N-1, go to EDGE_RD with i=0.
- EDGE_RD / EDGE_POSA / EDGE_POSB:
  - Read a=ea[i] and b=eb[i], then the positions of a and b.
  - Any coordinate -1 → UNPLACED.
  - Any coordinate <0 or ≥N (other than -1) → OUT_OF_RANGE.
  - a≠b with identical positions → OVERLAP.
- EDGE_GRID: read grid[xa*N+ya] and grid[xb*N+yb] sequentially. A mismatch with a or b → POS_MISMATCH.
- EDGE_CALC:
  - dx=|xa-xb| and dy=|ya-yb|, computed in W-bit signed two's complement.
  - cost=dx+dy-1 and hop=(dx>>1)+dx[0]+(dy>>1)+dy[0]-1.
  - Negative results (a==b) are permitted.
- EDGE_OUT:
  - Assert edge_valid with stable idx/cost/hop until the cycle where edge_valid && edge_ready. That handshake cycle adds to sum/sum_1hop and increments i.
  - edge_valid deasserts the next cycle unless the following record is ready.
  - After i = N_EDGE-1 is accepted, go to FIN.
- On first error: stop, latch err_code/err_index, go to FIN. Partial sums are retained.
- FIN: done=1 for one cycle, pass=(err_code==0), busy drops the same cycle, return to IDLE.
- Result outputs hold until the next accepted start.
- cycles increments on every busy cycle, wrapping at 2^W.
- N_EDGE=0: skip the edge phase; pass if the grid scan passes.

Test Plan:
- N=4, N_EDGE=2, grid empty except node0@(0,0), node1@(0,3), node2@(2,1); edges (0,1),(1,2), edge_ready=1 → records (0,2,1),(1,3,1); sum=5, sum_1hop=2, pass=1, done one pulse.
- Same setup, edge_ready low for 5 cycles on record 0 → edge_valid and fields stable throughout; sums unchanged until handshake; final values identical to the first test.
- grid[5]=2 but px[2]=2, py[2]=1 (cell 9) → err_code=1, err_index=5, pass=0, no edge_valid ever asserted.
- Edge (0,3) with px[3]=-1 → err_code=2, err_index=edge idx; the preceding edge is accepted and summed.
- px[1]=4 with N=4 → err_code=3. Two nodes both at (1,1) with matching grid → err_code=5 or 1, whichever check is reached first per the FSM order.
- Assert reset during EDGE_OUT → next cycle all outputs at reset values, no done. Start during busy → ignored; cycles count unaffected.
